// File: rtl/wb_writeback_queue_pkg.sv
// Shared definitions for the writeback queue and its neighbours (decode, hazard units).
package wb_writeback_queue_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DEPTH  = 4;

  // Register $zero: never written, never reported as a pending write.
  localparam int unsigned ZERO_REG   = 0;

endpackage

// File: rtl/wb_writeback_queue_fifo.sv
// Circular buffer of {dst,data} entries: up to two pushes and one pop per cycle.
// Entries are also presented oldest-first with per-entry valid for the hazard scan.
module wb_writeback_queue_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned EW     = ADDR_W + DATA_W,
  parameter int unsigned PW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_a,
  input  logic [EW-1:0]       entry_a,
  input  logic                push_b,
  input  logic [EW-1:0]       entry_b,
  input  logic                pop,
  output logic [EW-1:0]       head,
  output logic [PW:0]         count,
  output logic [DEPTH*EW-1:0] age_entries,
  output logic [DEPTH-1:0]    age_valid
);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_b;

  // Second push lands behind the first when both arrive together.
  assign wr_b = push_a ? wr_ptr + PW'(1) : wr_ptr;
  assign head = mem[rd_ptr];

  // Entry storage; contents need no reset because valid derives from count.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= entry_a;
    if (push_b) mem[wr_b]   <= entry_b;
  end

  // Pointer and count update; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count  <= count + (PW+1)'(push_a) + (PW+1)'(push_b) - (PW+1)'(pop);
    end
  end

  // Age-ordered view: slot 0 is the oldest (head), higher slots are younger.
  always_comb begin
    age_entries = '0;
    age_valid   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      age_entries[k*EW +: EW] = mem[rd_ptr + PW'(k)];
      age_valid[k]            = ((PW+1)'(k) < count);
    end
  end

endmodule

// File: rtl/wb_writeback_queue.sv
// Writeback queue: arbitrates ALU/load results into an in-order queue, drives the
// register-file write port one entry per cycle, and reports pending-write hazards.
module wb_writeback_queue
  import wb_writeback_queue_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_dst,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_dst,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     wb_hold,
  output logic                     reg_write,
  output logic                     reg_dst,
  output logic [ADDR_W-1:0]        rd_add,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        q_rs,
  input  logic [ADDR_W-1:0]        q_rt,
  output logic                     hz_rs,
  output logic                     hz_rt,
  output logic [DATA_W-1:0]        fwd_rs_data,
  output logic [DATA_W-1:0]        fwd_rt_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     empty
);

  localparam int unsigned EW = ADDR_W + DATA_W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic                push_alu;
  logic                push_ld;
  logic                pop;
  logic [EW-1:0]       head;
  logic [DEPTH*EW-1:0] age_entries;
  logic [DEPTH-1:0]    age_valid;

  // Readiness from registered occupancy only; ALU keeps the last free slot.
  assign alu_ready = (occupancy < CW'(DEPTH));
  assign ld_ready  = (occupancy <= CW'(DEPTH - 2));

  // Writes to $zero complete the handshake but are dropped here.
  assign push_alu = alu_valid && alu_ready && (alu_dst != ZA);
  assign push_ld  = ld_valid  && ld_ready  && (ld_dst  != ZA);
  assign pop      = (occupancy != '0) && !wb_hold;

  assign reg_dst  = reg_write;
  assign empty    = (occupancy == '0) && !reg_write;

  wb_writeback_queue_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_a      (push_alu),
    .entry_a     ({alu_dst, alu_data}),
    .push_b      (push_ld),
    .entry_b     ({ld_dst, ld_data}),
    .pop         (pop),
    .head        (head),
    .count       (occupancy),
    .age_entries (age_entries),
    .age_valid   (age_valid)
  );

  // Output stage: one-cycle write pulse; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write  <= 1'b0;
      rd_add     <= '0;
      write_data <= '0;
    end else begin
      reg_write <= pop;
      if (pop) begin
        rd_add     <= head[EW-1 -: ADDR_W];
        write_data <= head[DATA_W-1:0];
      end
    end
  end

  // Hazard scan: output stage first, then queue oldest-to-youngest so the youngest match wins.
  always_comb begin
    hz_rs       = 1'b0;
    hz_rt       = 1'b0;
    fwd_rs_data = '0;
    fwd_rt_data = '0;
    if (reg_write && (rd_add == q_rs) && (q_rs != ZA)) begin
      hz_rs       = 1'b1;
      fwd_rs_data = write_data;
    end
    if (reg_write && (rd_add == q_rt) && (q_rt != ZA)) begin
      hz_rt       = 1'b1;
      fwd_rt_data = write_data;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && (age_entries[k*EW + DATA_W +: ADDR_W] == q_rs) && (q_rs != ZA)) begin
        hz_rs       = 1'b1;
        fwd_rs_data = age_entries[k*EW +: DATA_W];
      end
      if (age_valid[k] && (age_entries[k*EW + DATA_W +: ADDR_W] == q_rt) && (q_rt != ZA)) begin
        hz_rt       = 1'b1;
        fwd_rt_data = age_entries[k*EW +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_wb_writeback_queue.sv
// Directed bench for wb_writeback_queue with a write-order scoreboard.
module tb_wb_writeback_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, ld_valid, wb_hold;
  logic              alu_ready, ld_ready;
  logic [ADDR_W-1:0] alu_dst, ld_dst, q_rs, q_rt;
  logic [DATA_W-1:0] alu_data, ld_data;
  logic              reg_write, reg_dst, hz_rs, hz_rt, empty;
  logic [ADDR_W-1:0] rd_add;
  logic [DATA_W-1:0] write_data, fwd_rs_data, fwd_rt_data;
  logic [$clog2(DEPTH):0] occupancy;

  int checks = 0;
  int passes = 0;
  logic [ADDR_W+DATA_W-1:0] sb [$];

  always #5 clk = ~clk;

  wb_writeback_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_dst     (alu_dst),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_dst      (ld_dst),
    .ld_data     (ld_data),
    .wb_hold     (wb_hold),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .rd_add      (rd_add),
    .write_data  (write_data),
    .q_rs        (q_rs),
    .q_rt        (q_rt),
    .hz_rs       (hz_rs),
    .hz_rt       (hz_rt),
    .fwd_rs_data (fwd_rs_data),
    .fwd_rt_data (fwd_rt_data),
    .occupancy   (occupancy),
    .empty       (empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expect a write for this accepted result; $zero results produce none.
  task automatic push_exp(input logic [ADDR_W-1:0] dst, input logic [DATA_W-1:0] data);
    if (dst != '0) sb.push_back({dst, data});
  endtask

  // Compare every issued write against the oldest expected one.
  task automatic mon();
    logic [ADDR_W+DATA_W-1:0] e;
    if (reg_write) begin
      chk("reg_dst_eq_reg_write", reg_dst, 1'b1);
      if (sb.size() == 0) begin
        chk("unexpected_write", reg_write, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("wr_rd_add", rd_add, e[ADDR_W+DATA_W-1 -: ADDR_W]);
        chk("wr_data", write_data, e[DATA_W-1:0]);
      end
    end else begin
      chk("reg_dst_idle", reg_dst, 1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !empty) && n < 30) begin
      tick();
      n++;
    end
    chk("drain_sb_empty", 64'(sb.size()), 0);
    chk("drain_empty", empty, 1'b1);
  endtask

  task automatic alu_put(input logic [ADDR_W-1:0] dst, input logic [DATA_W-1:0] data);
    alu_valid = 1'b1; alu_dst = dst; alu_data = data;
    push_exp(dst, data);
    tick();
    alu_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alu_valid = 0; ld_valid = 0; wb_hold = 0;
    alu_dst = '0; alu_data = '0; ld_dst = '0; ld_data = '0; q_rs = '0; q_rt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_reg_dst", reg_dst, 1'b0);
    chk("rst_rd_add", rd_add, '0);
    chk("rst_write_data", write_data, '0);
    chk("rst_occupancy", occupancy, '0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_ld_ready", ld_ready, 1'b1);

    // Reset during traffic: r5/r6/r7 queued under hold, then dropped
    wb_hold = 1'b1;
    alu_put(5, 32'h55); alu_put(6, 32'h66); alu_put(7, 32'h77);
    chk("t1_occ3", occupancy, 3);
    rst = 1'b1;
    #1;
    chk("t1_async_occ", occupancy, 0);
    chk("t1_async_reg_write", reg_write, 1'b0);
    chk("t1_async_empty", empty, 1'b1);
    sb.delete();
    tick();
    rst = 1'b0; wb_hold = 1'b0;
    repeat (4) tick();
    chk("t1_no_write_occ", occupancy, 0);

    // Single ALU write: latency and hazard window
    q_rt = 8;
    alu_put(8, 32'h1234);
    chk("t2_reg_write_N", reg_write, 1'b0);
    chk("t2_hz_rt_queue", hz_rt, 1'b1);
    chk("t2_fwd_rt_queue", fwd_rt_data, 32'h1234);
    tick();
    chk("t2_reg_write_N1", reg_write, 1'b1);
    chk("t2_hz_rt_out", hz_rt, 1'b1);
    chk("t2_fwd_rt_out", fwd_rt_data, 32'h1234);
    tick();
    chk("t2_reg_write_N2", reg_write, 1'b0);
    chk("t2_hz_rt_clear", hz_rt, 1'b0);
    chk("t2_hold_rd_add", rd_add, 8);
    chk("t2_hold_data", write_data, 32'h1234);
    q_rt = 0;

    // Simultaneous ALU + load: ALU entry is older
    alu_valid = 1; alu_dst = 3; alu_data = 32'hA;
    ld_valid  = 1; ld_dst  = 4; ld_data  = 32'hB;
    push_exp(3, 32'hA); push_exp(4, 32'hB);
    tick();
    alu_valid = 0; ld_valid = 0;
    chk("t3_occ2", occupancy, 2);
    tick();
    chk("t3_first_r3", rd_add, 3);
    tick();
    chk("t3_second_r4", rd_add, 4);
    drain();

    // Near-full priority
    wb_hold = 1'b1;
    alu_put(10, 32'h10); alu_put(11, 32'h11); alu_put(12, 32'h12);
    alu_valid = 1; alu_dst = 13; alu_data = 32'h13;
    ld_valid  = 1; ld_dst  = 14; ld_data  = 32'h14;
    chk("t4_alu_ready_free1", alu_ready, 1'b1);
    chk("t4_ld_ready_free1", ld_ready, 1'b0);
    push_exp(13, 32'h13);
    tick();
    alu_valid = 0; wb_hold = 0;
    chk("t4_occ_full", occupancy, 4);
    chk("t4_alu_ready_full", alu_ready, 1'b0);
    chk("t4_ld_ready_full", ld_ready, 1'b0);
    tick();
    chk("t4_ld_ready_occ3", ld_ready, 1'b0);
    tick();
    chk("t4_ld_ready_occ2", ld_ready, 1'b1);
    push_exp(14, 32'h14);
    tick();
    ld_valid = 0;
    chk("t4_occ_push_pop", occupancy, 2);
    drain();

    // Forward priority: youngest value wins
    wb_hold = 1'b1; q_rs = 9;
    alu_put(9, 32'h1); alu_put(9, 32'h2);
    chk("t5_hz_rs", hz_rs, 1'b1);
    chk("t5_fwd_young", fwd_rs_data, 32'h2);
    q_rt = 0;
    chk("t5_zero_no_hz", hz_rt, 1'b0);
    wb_hold = 1'b0;
    tick();
    chk("t5_fwd_queue_over_out", fwd_rs_data, 32'h2);
    tick();
    chk("t5_fwd_out", fwd_rs_data, 32'h2);
    tick();
    chk("t5_hz_rs_clear", hz_rs, 1'b0);
    q_rs = 0;

    // $zero and wrap: 10 back-to-back ALU writes, dst 0..9
    for (int i = 0; i < 10; i++) begin
      chk("t6_alu_ready", alu_ready, 1'b1);
      alu_put(ADDR_W'(i), 32'h100 + 32'(i));
      alu_valid = 1'b0;
      chk("t6_occ_bound", 64'(occupancy <= DEPTH), 1);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
